// File: rtl/draw_pkg.sv
// draw_pkg: shared types and defaults for the draw framebuffer writer/reader pair
// Contents: FSM state enum, default window BASE/COUNT, pair struct.
package draw_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int DRAW_BASE   = 3072;
    localparam int DRAW_COUNT  = 128;
    localparam int DRAW_DATA_W = 8;
    localparam int DRAW_IDX_W  = $clog2(DRAW_COUNT);
    typedef struct packed {
        logic [DRAW_DATA_W-1:0] q_b;
        logic [DRAW_DATA_W-1:0] q_a;
        logic [DRAW_IDX_W-1:0]  index;
    } pair_t;
endpackage

// File: rtl/draw_pair_fifo.sv
// draw_pair_fifo: synchronous FIFO buffering returned read pairs
// Ports: clk, reset (async, active-low), push/din, pop/dout (head word), full, empty, count.
module draw_pair_fifo
    import draw_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_pop;
    assign do_pop = pop && !empty;
    assign empty  = count == '0;
    assign full   = count == CW'(DEPTH);
    assign dout   = mem[rd_ptr];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/draw_pair_reader.sv
// draw_pair_reader: scans a window of even/odd RAM word pairs and streams them out
// Ports: clk, reset (async, active-low), start/busy/done control, mem_rd_en/mem_addr_a/
// mem_addr_b/mem_q_a/mem_q_b RAM read side, out_data/out_index/out_valid/out_ready stream,
// checksum (only when DRAW_READER_CHECKSUM_EN is defined).
module draw_pair_reader
    import draw_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = DRAW_DATA_W,
    parameter int BASE       = DRAW_BASE,
    parameter int COUNT      = DRAW_COUNT,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4,
    localparam int IDX_W     = (COUNT > 1) ? $clog2(COUNT) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr_a,
    output logic [ADDR_W-1:0]   mem_addr_b,
    input  logic [DATA_W-1:0]   mem_q_a,
    input  logic [DATA_W-1:0]   mem_q_b,
    output logic [2*DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]    out_index,
    output logic                out_valid,
    input  logic                out_ready
`ifdef DRAW_READER_CHECKSUM_EN
    ,
    output logic [2*DATA_W-1:0] checksum
`endif
);
    localparam int CNT_W = $clog2(COUNT + 1);
    localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int PW    = 2 * DATA_W + IDX_W;
    state_t state;
    logic [CNT_W-1:0] issued;
    logic [FC_W-1:0] inflight, fifo_count;
    logic [RD_LAT-1:0] tag;
    logic [IDX_W-1:0] tag_idx [RD_LAT];
    logic [PW-1:0] fifo_dout;
    logic accept, push, fifo_push, pop, empty, full;
    // a start coinciding with done is dropped so back-to-back scans need a fresh request
    assign accept     = state == IDLE && start && !done;
    // credit: reads in flight plus buffered pairs never exceed the buffer, so returns always fit
    assign mem_rd_en  = state == RUN && issued < CNT_W'(COUNT) && (inflight + fifo_count) < FC_W'(FIFO_DEPTH);
    assign mem_addr_b = mem_addr_a + ADDR_W'(1);
    assign busy       = state != IDLE;
    assign push       = tag[RD_LAT-1];
    assign fifo_push  = push && (!full || pop);
    assign out_valid  = !empty;
    assign pop        = out_valid && out_ready;
    assign {out_index, out_data} = fifo_dout;
    draw_pair_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (pop),
        .din   ({tag_idx[RD_LAT-1], mem_q_b, mem_q_a}),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );
    // each issued read carries its pair index down a pipe matching the RAM latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_idx[i] <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                tag[i]     <= tag[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end
            tag[0]     <= mem_rd_en;
            tag_idx[0] <= IDX_W'(issued);
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            issued     <= '0;
            inflight   <= '0;
            mem_addr_a <= ADDR_W'(BASE);
            done       <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= inflight + FC_W'(mem_rd_en) - FC_W'(push);
            if (mem_rd_en) begin
                issued     <= issued + 1'b1;
                mem_addr_a <= mem_addr_a + ADDR_W'(2);
            end
            case (state)
                IDLE: if (accept) begin
                    state      <= RUN;
                    issued     <= '0;
                    inflight   <= '0;
                    mem_addr_a <= ADDR_W'(BASE);
                end
                RUN: if (issued == CNT_W'(COUNT)) state <= DRAIN;
                // finish on the edge that pops the last pair so done lands right after it
                DRAIN: if (inflight == '0 && (empty || (pop && fifo_count == FC_W'(1)))) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef DRAW_READER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) checksum <= '0;
        else if (accept) checksum <= '0;
        else if (pop) checksum <= checksum + out_data;
    end
`endif
endmodule

// File: tb/tb_draw_pair_reader.sv
// tb_draw_pair_reader: randomized self-checking bench against a pair-sequence reference model
module tb_draw_pair_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;
    int n_chk = 0;
    int n_err = 0;
    logic [2:0] rst_n, start, ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] exp_pair(input int k);
        logic [7:0] lo, hi;
        lo = 8'((3072 + 2 * k) % 256);
        hi = 8'((3072 + 2 * k + 1) % 256);
        return {hi, lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int RL = (g == 1) ? 3 : 1;
        localparam int CN = (g == 2) ? 1 : 128;
        localparam int IW = (CN > 1) ? $clog2(CN) : 1;
        logic busy, done, rd_en, valid;
        logic [13:0] addr_a, addr_b;
        logic [7:0] qa, qb;
        logic [15:0] data;
        logic [IW-1:0] idx;
        logic [13:0] pa [RL];
        logic [13:0] pb [RL];
        int exp_k, n_rd, n_done, t0, t_rd, t_val, t_done;
        logic [15:0] sum, last_data;
        logic [IW-1:0] last_idx;
        logic stalled;
`ifdef DRAW_READER_CHECKSUM_EN
        logic [15:0] cs;
`endif
        // RAM holding mem[a] = a[7:0], returning data RL cycles after the read
        always @(posedge clk) begin
            pa[0] <= addr_a;
            pb[0] <= addr_b;
            for (int i = 1; i < RL; i++) begin
                pa[i] <= pa[i-1];
                pb[i] <= pb[i-1];
            end
        end
        assign qa = pa[RL-1][7:0];
        assign qb = pb[RL-1][7:0];

        draw_pair_reader #(
            .ADDR_W(14), .DATA_W(8), .BASE(3072), .COUNT(CN), .RD_LAT(RL), .FIFO_DEPTH(4)
        ) dut (
            .clk        (clk),
            .reset      (rst_n[g]),
            .start      (start[g]),
            .busy       (busy),
            .done       (done),
            .mem_rd_en  (rd_en),
            .mem_addr_a (addr_a),
            .mem_addr_b (addr_b),
            .mem_q_a    (qa),
            .mem_q_b    (qb),
            .out_data   (data),
            .out_index  (idx),
            .out_valid  (valid),
            .out_ready  (ready[g])
`ifdef DRAW_READER_CHECKSUM_EN
            ,
            .checksum   (cs)
`endif
        );

        // reference model: the scan is the sequence k = 0..CN-1 of pair(k), issued and consumed in order
        always @(negedge clk) begin
            if (!rst_n[g]) begin
                exp_k = 0; n_rd = 0; n_done = 0; sum = '0; stalled = 1'b0;
                t0 = 0; t_rd = -1; t_val = -1; t_done = -1;
            end else begin
                if (busy) check("credit", 32'(n_rd - exp_k <= 4), 32'd1);
                if (start[g] && !busy && !done) begin
                    t0 = cyc; exp_k = 0; n_rd = 0; n_done = 0; sum = '0;
                    t_rd = -1; t_val = -1; t_done = -1;
                end
                if (rd_en) begin
                    if (t_rd < 0) t_rd = cyc;
                    check("addr_a", addr_a, 14'(3072 + 2 * n_rd));
                    check("addr_b", addr_b, 14'(3073 + 2 * n_rd));
                    n_rd++;
                end
                if (stalled) begin
                    check("hold_data", data, last_data);
                    check("hold_idx", idx, last_idx);
                end
                if (valid && t_val < 0) t_val = cyc;
                if (valid && ready[g]) begin
                    check("idx", idx, exp_k);
                    check("data", data, exp_pair(exp_k));
                    sum = sum + data;
                    exp_k++;
                end
                stalled = valid && !ready[g];
                last_data = data;
                last_idx = idx;
                if (done) begin
                    n_done++;
                    t_done = cyc;
                end
            end
        end
    end

    initial begin
        rst_n = '0;
        start = '0;
        ready = 3'b111;
        repeat (3) tick();
        check("rst_busy", u[0].busy, 0);
        check("rst_done", u[0].done, 0);
        check("rst_rd_en", u[0].rd_en, 0);
        check("rst_valid", u[0].valid, 0);
        check("rst_addr_a", u[0].addr_a, 3072);
        check("rst_addr_b", u[0].addr_b, 3073);
        check("rst_data", u[0].data, 0);
        check("rst_idx", u[0].idx, 0);
        check("rst_addr_a_c1", u[2].addr_a, 3072);
`ifdef DRAW_READER_CHECKSUM_EN
        check("rst_checksum", u[0].cs, 0);
`endif
        rst_n = 3'b111;
        tick();

        // streaming scan with ignored starts during RUN and in the done cycle
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        repeat (9) tick();
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        for (int i = 0; i < 1000 && !u[0].done; i++) tick();
        check("stream_done_seen", u[0].done, 1);
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        check("done_one_cycle", u[0].done, 0);
        check("busy_after_done", u[0].busy, 0);
        check("stream_pairs", u[0].exp_k, 128);
        check("stream_reads", u[0].n_rd, 128);
        check("stream_ndone", u[0].n_done, 1);
        check("first_rd_lat", u[0].t_rd - u[0].t0, 1);
        check("first_valid_lat", u[0].t_val - u[0].t0, 3);
        check("done_lat", u[0].t_done - u[0].t0, 131);
`ifdef DRAW_READER_CHECKSUM_EN
        check("stream_checksum", u[0].cs, u[0].sum);
`endif
        repeat (5) tick();
        check("done_start_ignored", u[0].busy, 0);
        check("single_done", u[0].n_done, 1);

        // random backpressure at 30% ready duty
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        for (int i = 0; i < 5000 && !u[0].done; i++) begin
            ready[0] = ($urandom_range(0, 9) < 3);
            tick();
        end
        check("bp_done_seen", u[0].done, 1);
        tick();
        ready[0] = 1'b1;
        check("bp_pairs", u[0].exp_k, 128);
        check("bp_ndone", u[0].n_done, 1);
`ifdef DRAW_READER_CHECKSUM_EN
        check("bp_checksum", u[0].cs, u[0].sum);
`endif

        // RD_LAT=3 with the stream blocked: credit allows exactly four reads
        ready[1] = 1'b0;
        start[1] = 1'b1; tick(); start[1] = 1'b0;
        repeat (20) tick();
        check("lat3_stall_reads", u[1].n_rd, 4);
        check("lat3_stall_valid", u[1].valid, 1);
        ready[1] = 1'b1;
        for (int i = 0; i < 1000 && !u[1].done; i++) tick();
        check("lat3_done_seen", u[1].done, 1);
        tick();
        check("lat3_pairs", u[1].exp_k, 128);
        check("lat3_ndone", u[1].n_done, 1);

        // asynchronous reset mid-scan, then a clean rescan
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        for (int i = 0; i < 500 && u[0].exp_k < 50; i++) tick();
        check("abort_point", u[0].exp_k, 50);
        #2 rst_n[0] = 1'b0;
        #1;
        check("abort_busy", u[0].busy, 0);
        check("abort_rd_en", u[0].rd_en, 0);
        check("abort_valid", u[0].valid, 0);
        check("abort_addr_a", u[0].addr_a, 3072);
        check("abort_addr_b", u[0].addr_b, 3073);
        check("abort_data", u[0].data, 0);
        check("abort_idx", u[0].idx, 0);
`ifdef DRAW_READER_CHECKSUM_EN
        check("abort_checksum", u[0].cs, 0);
`endif
        tick(); tick();
        rst_n[0] = 1'b1;
        repeat (3) tick();
        check("abort_stays_idle", u[0].busy, 0);
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        for (int i = 0; i < 1000 && !u[0].done; i++) tick();
        check("rescan_done_seen", u[0].done, 1);
        tick();
        check("rescan_pairs", u[0].exp_k, 128);
        check("rescan_done_lat", u[0].t_done - u[0].t0, 131);

        // COUNT=1
        start[2] = 1'b1; tick(); start[2] = 1'b0;
        for (int i = 0; i < 100 && !u[2].done; i++) tick();
        check("c1_done_seen", u[2].done, 1);
        tick();
        check("c1_pairs", u[2].exp_k, 1);
        check("c1_reads", u[2].n_rd, 1);
        check("c1_done_lat", u[2].t_done - u[2].t0, 4);
        check("c1_ndone", u[2].n_done, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/draw_pair_reader.md
# draw_pair_reader

Read-side scanner for the draw framebuffer's dual-port RAM. On a start pulse it walks a fixed window of even/odd word pairs, issuing paired read addresses on ports A and B. It absorbs the RAM's fixed read latency and delivers each pair downstream over a valid/ready stream. It is the consumer of the region the draw address counter fills: port A reads even addresses and port B reads odd addresses.

## Interface
- ADDR_W, 14: RAM word-address width.
- DATA_W, 8: width of one RAM word.
- BASE, 3072: first (even) address of the window. Must be even.
- COUNT, 128: number of pairs per scan, ≥1. BASE+2·COUNT−1 must fit in ADDR_W.
- RD_LAT, 1: fixed RAM read latency in cycles, 1..4.
- FIFO_DEPTH, 4: output buffer depth, a power of two, ≥ RD_LAT+1.

Ports:
- clk, in, 1: clock.
- reset, in, 1: reset, asynchronous, active-low; clock clk.
- start, in, 1: one-cycle scan request. Ignored while busy=1.
- busy, out, 1: high from the cycle after an accepted start until done.
- done, out, 1: one-cycle pulse after the last pair is accepted downstream.
- mem_rd_en, out, 1: read strobe for both RAM ports.
- mem_addr_a, out, ADDR_W: even read address (port A).
- mem_addr_b, out, ADDR_W: odd read address (port B), always mem_addr_a+1.
- mem_q_a, in, DATA_W: port A read data.
- mem_q_b, in, DATA_W: port B read data.
- out_data, out, 2·DATA_W: {q_b, q_a} for the pair.
- out_index, out, $clog2(COUNT): pair index k of out_data.
- out_valid, out, 1: out_data and out_index are valid.
- out_ready, in, 1: downstream accepts the pair.
- checksum, out, 2·DATA_W: present only with DRAW_READER_CHECKSUM_EN.

## Operation
- FSM states:
  - IDLE: start=1 goes to RUN and clears the issue counter, the inflight count and the checksum.
  - RUN: leaves when the issued count reaches COUNT, going to DRAIN.
  - DRAIN: when the FIFO is empty, inflight=0 and the final handshake has completed, pulses done and returns to IDLE.
- busy=1 in RUN and DRAIN.
- Read issue (RUN only): mem_rd_en=1 when issued<COUNT and inflight+fifo_count < FIFO_DEPTH (credit rule). The credit rule guarantees returning data never overflows the FIFO.
- Pair k: mem_addr_a = BASE+2k, mem_addr_b = BASE+2k+1. The addresses increment only on an issued read and hold otherwise.
- Latency: an RD_LAT-deep valid shift register tags each read. When a tag exits, {mem_q_b, mem_q_a} and k are pushed into the FIFO.
- Output: out_valid = FIFO not empty. A pair pops on out_valid & out_ready. Pairs are emitted in strictly ascending k, with none dropped or duplicated.
- Simultaneous FIFO push and pop in one cycle is legal; the count is unchanged.
- The issue counter is $clog2(COUNT+1) bits wide. Arithmetic is unsigned, with no wrap inside a scan.
- Reset mid-scan aborts immediately: FIFO and inflight are flushed, and the next scan requires a new start.

## Timing
- Reset values:
  - busy=0, done=0, mem_rd_en=0, out_valid=0.
  - mem_addr_a=BASE, mem_addr_b=BASE+1.
  - out_data=0, out_index=0, checksum=0.
- start is sampled at cycle t. The first mem_rd_en is at t+1. The first out_valid is at t+1+RD_LAT+1, one cycle for the FIFO register.
- With out_ready held at 1: one pair per cycle. The last pair is at t+COUNT+RD_LAT+1 and done is the following cycle.
- done is high for exactly 1 cycle. busy drops in the same cycle done is high.
- out_data and out_index must remain stable while out_valid=1 and out_ready=0.
- A start in the same cycle as done is ignored. start is accepted one cycle later, in IDLE.

## Configuration
- DRAW_READER_CHECKSUM_EN, defined:
  - Adds the checksum port.
  - checksum = 2·DATA_W-bit modular sum of every accepted out_data in the current scan.
  - Updates on each pop and is cleared on start.
  - Final value is valid when done is high and held until the next start.
- Undefined: no port and no adder; all other behaviour is identical.

## Structure
- Package draw_pkg:
  - FSM state enum (IDLE, RUN, DRAIN).
  - Default BASE/COUNT constants shared with the draw writer.
  - Pair typedef (struct of q_a, q_b, index).
- One sub-module, draw_pair_fifo: synchronous FIFO with parameters DEPTH and WIDTH, and ports push/pop/full/empty/count. The top holds the FSM, counters and latency pipe.

## Test plan
- Streaming scan: RAM model holds mem[a]=a[7:0], RD_LAT=1, out_ready=1, start pulse.
  - Expect 128 pairs, k=0..127, out_data={(3072+2k+1)[7:0],(3072+2k)[7:0]}.
  - done at start+131, checksum = sum of all pairs.
- Backpressure: out_ready toggles at random at 30% duty.
  - Same pair sequence, no loss.
  - out_data stable while stalled.
  - inflight+fifo_count never exceeds 4.
- RD_LAT=3, out_ready=0 for 20 cycles after start.
  - mem_rd_en asserts exactly 4 times, then stalls.
  - After release all 128 pairs arrive in order.
- start pulsed during RUN and in the done cycle: both ignored, exactly one done.
- Reset asserted mid-scan at pair 50.
  - All outputs return to reset values asynchronously.
  - A subsequent start produces a clean scan from k=0.
- COUNT=1: single pair at addresses 3072/3073, done one cycle after its handshake.
